// File: rtl/riscv_aes_pkg.sv
// Shared types and default widths for the AES write-back path.
package riscv_aes_pkg;

    localparam int unsigned AES_BLOCK_W = 128;
    localparam int unsigned AES_BUS_W   = 32;
    localparam int unsigned AES_ADDR_W  = 32;

    typedef enum logic {IDLE, BEAT} wb_state_e;

    typedef struct packed {
        logic [AES_ADDR_W-1:0]  address;
        logic [AES_BLOCK_W-1:0] data;
    } wb_entry_t;

endpackage

// File: rtl/riscv_aes_wb_fifo.sv
// Generic synchronous FIFO; exposes the head and the entry behind it for
// zero-bubble hand-over by the consumer.
module riscv_aes_wb_fifo #(
    parameter int unsigned WIDTH = 160,
    parameter int unsigned DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic                         pop,
    input  logic [WIDTH-1:0]             wdata,
    output logic [WIDTH-1:0]             rdata,
    output logic [WIDTH-1:0]             rdata_next,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic                         empty
);

    localparam int unsigned CW = $clog2(DEPTH + 1);
    localparam int unsigned PW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    rd_ptr;
    logic [PW-1:0]    wr_ptr;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wdata;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign rdata      = mem[rd_ptr];
    assign rdata_next = mem[rd_ptr + 1'b1];
    assign full       = (count == CW'(DEPTH));
    assign empty      = (count == '0);

endmodule

// File: rtl/riscv_aes_wb_queue.sv
// Buffered AES write-back: queues ciphered blocks and drains each one to
// memory as MS-word-first bus beats under a grant handshake.
module riscv_aes_wb_queue
    import riscv_aes_pkg::*;
#(
    parameter int unsigned BLOCK_WIDTH = AES_BLOCK_W,
    parameter int unsigned BUS_WIDTH   = AES_BUS_W,
    parameter int unsigned ADDR_WIDTH  = AES_ADDR_W,
    parameter int unsigned DEPTH       = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   start_aes_wb,
    input  logic [ADDR_WIDTH-1:0]  address_in,
    input  logic [BLOCK_WIDTH-1:0] data_in,
    input  logic                   gnt_i,
    output logic                   write_en_out,
    output logic [ADDR_WIDTH-1:0]  address_out,
    output logic [BUS_WIDTH-1:0]   data_out,
    output logic                   halt_en_out,
    output logic                   busy_o,
    output logic                   done_o,
    output logic                   overflow_o
);

    localparam int unsigned BEATS = BLOCK_WIDTH / BUS_WIDTH;
    localparam int unsigned BSTEP = BUS_WIDTH / 8;
    localparam int unsigned BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int unsigned CW    = $clog2(DEPTH + 1);
    localparam int unsigned EW    = ADDR_WIDTH + BLOCK_WIDTH;
    localparam logic [BW-1:0] LAST_BEAT = BW'(BEATS - 1);

    wb_state_e             state, state_next;
    logic [BW-1:0]         beat, beat_next;
    logic [EW-1:0]         head, head_behind, head_after, push_entry;
    logic [CW-1:0]         count, count_next;
    logic                  full, empty, push, pop;
    logic                  we_next, done_next;
    logic [ADDR_WIDTH-1:0] addr_next;
    logic [BUS_WIDTH-1:0]  data_next;

    function automatic logic [ADDR_WIDTH-1:0] beat_addr(input logic [EW-1:0] e,
                                                        input int unsigned b);
        return e[EW-1 -: ADDR_WIDTH] + ADDR_WIDTH'(b * BSTEP);
    endfunction

    function automatic logic [BUS_WIDTH-1:0] beat_data(input logic [EW-1:0] e,
                                                       input int unsigned b);
        return e[BLOCK_WIDTH-1 - b*BUS_WIDTH -: BUS_WIDTH];
    endfunction

    riscv_aes_wb_fifo #(
        .WIDTH (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .push       (push),
        .pop        (pop),
        .wdata      (push_entry),
        .rdata      (head),
        .rdata_next (head_behind),
        .count      (count),
        .full       (full),
        .empty      (empty)
    );

    // The in-flight block stays in the queue until its last beat is granted,
    // so a full queue can still accept a push on that same edge.
    assign push_entry = {address_in, data_in};
    assign pop        = (state == BEAT) && write_en_out && gnt_i && (beat == LAST_BEAT);
    assign push       = start_aes_wb && (!full || pop);
    assign count_next = count + CW'(push) - CW'(pop);
    // With a single entry left, the successor is the block being pushed now.
    assign head_after = (count > CW'(1)) ? head_behind : push_entry;

    always_comb begin
        state_next = state;
        beat_next  = beat;
        we_next    = write_en_out;
        addr_next  = address_out;
        data_next  = data_out;
        done_next  = 1'b0;
        unique case (state)
            IDLE: begin
                we_next = 1'b0;
                if (!empty) begin
                    state_next = BEAT;
                    beat_next  = '0;
                end
            end
            BEAT: begin
                if (!write_en_out) begin
                    we_next   = 1'b1;
                    addr_next = beat_addr(head, 0);
                    data_next = beat_data(head, 0);
                end else if (gnt_i) begin
                    if (beat != LAST_BEAT) begin
                        beat_next = beat + 1'b1;
                        addr_next = beat_addr(head, 32'(beat) + 32'd1);
                        data_next = beat_data(head, 32'(beat) + 32'd1);
                    end else begin
                        done_next = 1'b1;
                        beat_next = '0;
                        if (count_next != '0) begin
                            addr_next = beat_addr(head_after, 0);
                            data_next = beat_data(head_after, 0);
                        end else begin
                            state_next = IDLE;
                            we_next    = 1'b0;
                        end
                    end
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            beat         <= '0;
            write_en_out <= 1'b0;
            address_out  <= '0;
            data_out     <= '0;
            done_o       <= 1'b0;
            halt_en_out  <= 1'b0;
            busy_o       <= 1'b0;
            overflow_o   <= 1'b0;
        end else begin
            state        <= state_next;
            beat         <= beat_next;
            write_en_out <= we_next;
            address_out  <= addr_next;
            data_out     <= data_next;
            done_o       <= done_next;
            halt_en_out  <= (count_next == CW'(DEPTH));
            busy_o       <= (count_next != '0) || (state_next == BEAT);
            if (start_aes_wb && !push) begin
                overflow_o <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_riscv_aes_wb_queue.sv
// Scoreboard bench for riscv_aes_wb_queue: stimulus queues expected beats,
// a negedge monitor checks every presented beat and done pulse.
module tb_riscv_aes_wb_queue;
    import riscv_aes_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
        bit          last;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_aes_wb = 1'b0;
    logic [31:0]  address_in = '0;
    logic [127:0] data_in = '0;
    logic         gnt_i = 1'b0;
    logic         write_en_out;
    logic [31:0]  address_out;
    logic [31:0]  data_out;
    logic         halt_en_out;
    logic         busy_o;
    logic         done_o;
    logic         overflow_o;

    beat_t        exp_q[$];
    int unsigned  n_checks = 0;
    int unsigned  n_fail = 0;
    int unsigned  beats_seen = 0;
    int unsigned  dones_seen = 0;
    int unsigned  cyc = 0;
    bit           done_exp = 1'b0;

    riscv_aes_wb_queue #(
        .BLOCK_WIDTH (128),
        .BUS_WIDTH   (32),
        .ADDR_WIDTH  (32),
        .DEPTH       (4)
    ) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .start_aes_wb (start_aes_wb),
        .address_in   (address_in),
        .data_in      (data_in),
        .gnt_i        (gnt_i),
        .write_en_out (write_en_out),
        .address_out  (address_out),
        .data_out     (data_out),
        .halt_en_out  (halt_en_out),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk = ~clk;

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Called at posedge+1; the push is sampled on the next rising edge.
    task automatic push(input wb_entry_t e, input bit accept);
        start_aes_wb = 1'b1;
        address_in   = e.address;
        data_in      = e.data;
        if (accept) begin
            for (int b = 0; b < 4; b++) begin
                beat_t t;
                t.addr = e.address + 32'(4 * b);
                t.data = e.data[127 - 32*b -: 32];
                t.last = (b == 3);
                exp_q.push_back(t);
            end
        end
        @(posedge clk);
        #1;
        start_aes_wb = 1'b0;
    endtask

    task automatic wait_drain(output int unsigned end_cyc);
        int unsigned n = 0;
        while ((busy_o || exp_q.size() != 0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        end_cyc = cyc;
        check("drain_busy", busy_o, 0);
        check("drain_scoreboard", exp_q.size(), 0);
        @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        rst_n = 1'b0;
        start_aes_wb = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_values();
        check("rst_write_en", write_en_out, 0);
        check("rst_address", address_out, 0);
        check("rst_data", data_out, 0);
        check("rst_halt", halt_en_out, 0);
        check("rst_busy", busy_o, 0);
        check("rst_done", done_o, 0);
        check("rst_overflow", overflow_o, 0);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                done_exp = 1'b0;
            end else begin
                check("done_o", done_o, done_exp);
                if (done_o) dones_seen++;
                done_exp = 1'b0;
                if (write_en_out) begin
                    check("beat_expected", exp_q.size() != 0, 1);
                    if (exp_q.size() != 0) begin
                        check("address_out", address_out, exp_q[0].addr);
                        check("data_out", data_out, exp_q[0].data);
                        if (gnt_i) begin
                            done_exp = exp_q[0].last;
                            void'(exp_q.pop_front());
                            beats_seen++;
                        end
                    end
                end
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached, got running, expected finished");
        $fatal(1, "watchdog");
    end

    initial begin
        wb_entry_t   e1, ew, ef, eg;
        wb_entry_t   blk[5];
        int unsigned b0, d0, c0, endc;

        e1 = {32'h0000_1000, 128'hdeadbeef_deafbabe_01234567_cafeface};
        ew = {32'hFFFF_FFF8, 128'h11111111_22222222_33333333_44444444};
        ef = {32'h0000_8000, 128'haaaa0000_bbbb1111_cccc2222_dddd3333};
        eg = {32'h0000_9000, 128'h01010101_02020202_03030303_04040404};
        for (int i = 0; i < 5; i++) begin
            blk[i].address = 32'h2000 + 32'(i) * 32'h100;
            blk[i].data    = {32'h1111_0000 + 32'(i), 32'h2222_0000 + 32'(i),
                              32'h3333_0000 + 32'(i), 32'h4444_0000 + 32'(i)};
        end

        gnt_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values();
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Single block, grant tied high; first beat two edges after the push
        b0 = beats_seen; d0 = dones_seen;
        push(e1, 1'b1);
        @(negedge clk); check("latency_edge_n", write_en_out, 0);
        @(negedge clk); check("latency_edge_n1", write_en_out, 0);
        @(negedge clk);
        check("latency_edge_n2", write_en_out, 1);
        check("first_addr", address_out, 32'h0000_1000);
        check("first_data", data_out, 32'hdeadbeef);
        wait_drain(endc);
        check("t1_beats", beats_seen - b0, 4);
        check("t1_dones", dones_seen - d0, 1);

        // Grant withheld for three cycles on beat 1
        b0 = beats_seen; d0 = dones_seen;
        push(e1, 1'b1);
        repeat (3) @(posedge clk);
        #1;
        gnt_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            check("stall_addr", address_out, 32'h0000_1004);
            check("stall_data", data_out, 32'hdeafbabe);
            check("stall_we", write_en_out, 1);
        end
        @(posedge clk);
        #1;
        gnt_i = 1'b1;
        wait_drain(endc);
        check("t2_beats", beats_seen - b0, 4);
        check("t2_dones", dones_seen - d0, 1);

        // Fill to DEPTH, drop a fifth push, then drain back-to-back
        gnt_i = 1'b0;
        push(blk[0], 1'b1);
        push(blk[1], 1'b1);
        push(blk[2], 1'b1);
        @(negedge clk); check("halt_at_3", halt_en_out, 0);
        @(posedge clk); #1;
        push(blk[3], 1'b1);
        @(negedge clk);
        check("halt_at_4", halt_en_out, 1);
        check("overflow_before_drop", overflow_o, 0);
        @(posedge clk); #1;
        push(blk[4], 1'b0);
        @(negedge clk);
        check("overflow_after_drop", overflow_o, 1);
        check("halt_after_drop", halt_en_out, 1);
        @(posedge clk); #1;
        b0 = beats_seen; d0 = dones_seen; c0 = cyc;
        gnt_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done_o) break;
            check("halt_held", halt_en_out, 1);
        end
        check("halt_clear", halt_en_out, 0);
        wait_drain(endc);
        check("t3_beats", beats_seen - b0, 16);
        check("t3_dones", dones_seen - d0, 4);
        check("t3_b2b_cycles", endc - c0, 16);
        check("overflow_sticky", overflow_o, 1);

        // Push on the same edge as the last-beat grant of a full queue
        apply_reset();
        check("t4_overflow_reset", overflow_o, 0);
        gnt_i = 1'b0;
        b0 = beats_seen; d0 = dones_seen;
        for (int i = 0; i < 4; i++) push(blk[i], 1'b1);
        @(negedge clk); check("t4_halt_full", halt_en_out, 1);
        @(posedge clk); #1;
        gnt_i = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        push(blk[4], 1'b1);
        @(negedge clk);
        check("t4_halt_kept", halt_en_out, 1);
        check("t4_no_overflow", overflow_o, 0);
        check("t4_done", done_o, 1);
        wait_drain(endc);
        check("t4_beats", beats_seen - b0, 20);
        check("t4_dones", dones_seen - d0, 5);
        check("t4_overflow_end", overflow_o, 0);

        // Address wrap at the top of the address space
        b0 = beats_seen;
        push(ew, 1'b1);
        repeat (5) @(negedge clk);
        check("wrap_addr2", address_out, 32'h0000_0000);
        @(negedge clk);
        check("wrap_addr3", address_out, 32'h0000_0004);
        wait_drain(endc);
        check("t5_beats", beats_seen - b0, 4);

        // Reset after beat 1 is granted abandons the block
        b0 = beats_seen;
        push(ef, 1'b1);
        repeat (4) @(posedge clk);
        #1;
        rst_n = 1'b0;
        exp_q.delete();
        check("t6_beats_before_reset", beats_seen - b0, 2);
        #1;
        check_reset_values();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        b0 = beats_seen;
        repeat (10) @(negedge clk);
        check("t6_no_beats_after", beats_seen - b0, 0);
        check("t6_idle_busy", busy_o, 0);
        @(posedge clk); #1;
        b0 = beats_seen; d0 = dones_seen;
        push(eg, 1'b1);
        wait_drain(endc);
        check("t6_fresh_beats", beats_seen - b0, 4);
        check("t6_fresh_dones", dones_seen - d0, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
